// File: rtl/updown_pkg.sv
// Shared definitions for the quadrature front-end and the up/down counter it feeds.
// Latency: n/a (constants, types and a pure decode function).
// Backpressure: n/a.
package updown_pkg;

    localparam int LD_W_DEF = 4;

    // Gray-coded {A,B} positions; forward rotation visits them in this order.
    localparam logic [1:0] QS_00 = 2'b00;
    localparam logic [1:0] QS_01 = 2'b01;
    localparam logic [1:0] QS_11 = 2'b11;
    localparam logic [1:0] QS_10 = 2'b10;

    typedef enum logic [1:0] {
        DIR_NONE    = 2'b00,
        DIR_UP      = 2'b01,
        DIR_DOWN    = 2'b10,
        DIR_ILLEGAL = 2'b11
    } step_dir_t;

    // Classify one {A,B} transition. Exactly one bit changing is always a legal
    // step; which direction depends on where we came from.
    function automatic step_dir_t step_dir(input logic [1:0] prev, input logic [1:0] cur);
        step_dir_t d;
        d = DIR_NONE;
        if (prev == cur) begin
            d = DIR_NONE;
        end else if ((prev ^ cur) == 2'b11) begin
            d = DIR_ILLEGAL;
        end else begin
            case (prev)
                QS_00:   d = (cur == QS_01) ? DIR_UP : DIR_DOWN;
                QS_01:   d = (cur == QS_11) ? DIR_UP : DIR_DOWN;
                QS_11:   d = (cur == QS_10) ? DIR_UP : DIR_DOWN;
                QS_10:   d = (cur == QS_00) ? DIR_UP : DIR_DOWN;
                default: d = DIR_NONE;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Synchroniser + debounce filter for one asynchronous level input.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES clocks from first sampling edge to dout change.
// Backpressure: none; free-running level path.
// Ports: clk, rst (async, active-high), din (raw async level), dout (filtered level).
module sync_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   filt_q;
    logic                   synced;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // The count tracks consecutive mismatching cycles. The edge on which it
    // would reach DEBOUNCE_CYCLES is the edge that commits the new level, so the
    // counter is cleared there instead of stored at its terminal value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else if (synced == filt_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q  <= '0;
            filt_q <= synced;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign dout = filt_q;

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature/preset front-end: conditions A, B and preset, emits unit up/down steps and load pulses.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES + 1 clocks from raw level sample to registered output pulse.
// Backpressure: none; pulses are fire-and-forget into the counter's en/ld/up/down inputs.
// Ports: clk, rst (async, active-high); a_in, b_in, preset_in raw async inputs; preset_val quasi-static
//        preset; up/down/en/err single-cycle pulses; ld registered preset, held after en.
module quad_step_decoder
    import updown_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LD_W            = LD_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_in,
    input  logic            b_in,
    input  logic            preset_in,
    input  logic [LD_W-1:0] preset_val,
    output logic            up,
    output logic            down,
    output logic            en,
    output logic [LD_W-1:0] ld,
    output logic            err
);

    // Filters can first move on edge SYNC_STAGES+DEBOUNCE_CYCLES after reset;
    // the decode of that move lands one edge later, so mask that edge too.
    localparam int STARTUP = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
    localparam int ST_W    = $clog2(STARTUP + 1);

    logic       a_f;
    logic       b_f;
    logic       pre_f;
    logic [1:0] cur_ab;
    logic [1:0] prev_ab;
    logic       pre_q;
    logic [ST_W-1:0] st_cnt;
    logic       startup;
    step_dir_t  dir;
    logic       pre_rise;
    logic       up_d;
    logic       down_d;
    logic       en_d;
    logic       err_d;

    sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_a (
        .clk(clk), .rst(rst), .din(a_in), .dout(a_f)
    );

    sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_b (
        .clk(clk), .rst(rst), .din(b_in), .dout(b_f)
    );

    sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pre (
        .clk(clk), .rst(rst), .din(preset_in), .dout(pre_f)
    );

    assign cur_ab  = {a_f, b_f};
    assign startup = (st_cnt != ST_W'(STARTUP));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_cnt <= '0;
        end else if (startup) begin
            st_cnt <= st_cnt + ST_W'(1);
        end
    end

    // History registers always follow the filtered levels, including during
    // startup and on illegal or suppressed transitions, so the next decode is
    // always relative to the true current position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_ab <= 2'b00;
            pre_q   <= 1'b0;
        end else begin
            prev_ab <= cur_ab;
            pre_q   <= pre_f;
        end
    end

    always_comb begin
        dir      = step_dir(prev_ab, cur_ab);
        pre_rise = pre_f & ~pre_q;
        up_d     = 1'b0;
        down_d   = 1'b0;
        en_d     = 1'b0;
        err_d    = 1'b0;
        if (!startup) begin
            en_d   = pre_rise;
            // A load takes priority: the counter cannot load and step at once.
            up_d   = (dir == DIR_UP)   && !pre_rise;
            down_d = (dir == DIR_DOWN) && !pre_rise;
            err_d  = (dir == DIR_ILLEGAL);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up   <= 1'b0;
            down <= 1'b0;
            en   <= 1'b0;
            err  <= 1'b0;
            ld   <= '0;
        end else begin
            up   <= up_d;
            down <= down_d;
            en   <= en_d;
            err  <= err_d;
            if (en_d) begin
                ld <= preset_val;
            end
        end
    end

endmodule
